// File: rtl/rf_port_arbiter_if.sv
// Request/grant/read-return bundle for one client of rf_port_arbiter.
// The master modport is the client; the slave modport is the arbiter.
interface rf_port_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing a 1R/1W register file between clients A and B,
// with registered RF ports, fixed-latency read return and an init sweep.
module rf_port_arbiter #(
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH      = 64,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  rf_port_arbiter_if.slave  a,
  rf_port_arbiter_if.slave  b,
  input  logic              init_start,
  output logic              init_busy,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdout,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdin,
  output logic              rf_wena
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StInit} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              prioB;
  logic              rdPend;
  logic              rdTag;
  logic              aRvalid;
  logic              bRvalid;
  logic [DATA_W-1:0] aRdata;
  logic [DATA_W-1:0] bRdata;

  logic              arbOpen;
  logic              pickA;
  logic              gntA;
  logic              gntB;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;

  // init_start wins over any pending request in the cycle it is sampled.
  always_comb begin
    arbOpen  = (state == StIdle) && !rst && !init_start;
    pickA    = a.req && (!b.req || !prioB);
    gntA     = arbOpen && pickA;
    gntB     = arbOpen && b.req && !pickA;
    selWe    = gntA ? a.we    : b.we;
    selAddr  = gntA ? a.addr  : b.addr;
    selWdata = gntA ? a.wdata : b.wdata;
  end

  assign a.gnt    = gntA;
  assign b.gnt    = gntB;
  assign a.rvalid = aRvalid;
  assign b.rvalid = bRvalid;
  assign a.rdata  = aRdata;
  assign b.rdata  = bRdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      prioB     <= 1'b0;
      rdPend    <= 1'b0;
      rdTag     <= 1'b0;
      aRvalid   <= 1'b0;
      bRvalid   <= 1'b0;
      aRdata    <= '0;
      bRdata    <= '0;
      init_busy <= 1'b0;
      rf_raddr  <= '0;
      rf_waddr  <= '0;
      rf_wdin   <= '0;
      rf_wena   <= 1'b0;
    end else begin
      rf_wena <= 1'b0;
      rdPend  <= 1'b0;
      aRvalid <= 1'b0;
      bRvalid <= 1'b0;

      // Read issued last cycle: rf_rdout now reflects rf_raddr.
      if (rdPend) begin
        if (rdTag) begin
          bRdata  <= rf_rdout;
          bRvalid <= 1'b1;
        end else begin
          aRdata  <= rf_rdout;
          aRvalid <= 1'b1;
        end
      end

      unique case (state)
        StIdle: begin
          if (init_start) begin
            state     <= StInit;
            cnt       <= '0;
            init_busy <= 1'b1;
          end else if (gntA || gntB) begin
            prioB <= gntA;
            if (selWe) begin
              rf_wena  <= 1'b1;
              rf_waddr <= selAddr;
              rf_wdin  <= selWdata;
            end else begin
              rf_raddr <= selAddr;
              rdPend   <= 1'b1;
              rdTag    <= gntB;
            end
          end
        end
        StInit: begin
          rf_wena  <= 1'b1;
          rf_waddr <= cnt;
          rf_wdin  <= INIT_VALUE;
          if (cnt == LastIdx) begin
            state     <= StIdle;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

- Shares the single-read/single-write 64×32 register file between two requester clients, A and B.
- Arbitrates with a round-robin pointer and drives the register-file ports from registered outputs.
- Returns read data to the winning client with a fixed latency.
- Includes an init sequencer that sweeps a constant value into all 64 entries on command.
- Sits between the register file and its users (datapath, debug/loader port).

## Interface

Parameters:
- ADDR_W, 6, register-file address width
- DATA_W, 32, data width
- DEPTH, 64, number of entries swept by init (2^ADDR_W)
- INIT_VALUE, 32'h0000_0000, value written by init sweep

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  client A request; held until granted
- a_we  in  1  client A op: 1 write, 0 read
- a_addr  in  ADDR_W  client A address
- a_wdata  in  DATA_W  client A write data
- a_gnt  out  1  client A request accepted this cycle (combinational)
- a_rvalid  out  1  client A read data valid (1-cycle pulse)
- a_rdata  out  DATA_W  client A read data, held until next A read returns
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for client B
- init_start  in  1  pulse: begin init sweep
- init_busy  out  1  sweep in progress
- rf_raddr  out  ADDR_W  register-file read address (registered)
- rf_rdout  in  DATA_W  register-file read data (combinational from rf_raddr)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdin  out  DATA_W  register-file write data (registered)
- rf_wena  out  1  register-file write enable (registered)

## Operation

- States: IDLE (arbitrating) and INIT (sweep). Reset enters IDLE with priority on A.
- Reset values: all outputs 0 (gnt, rvalid, rdata, rf_*, init_busy). The register-file contents are not touched by reset.

IDLE arbitration:
- At most one grant per cycle.
- With only one request pending, that request is granted.
- With both pending, the priority holder is granted.
- After any grant, priority moves to the other client. With no grant, priority is unchanged.
- A handshake completes in a cycle where req && gnt. The client may change req, we, addr and wdata in the next cycle.
- A granted write loads rf_waddr/rf_wdin and sets rf_wena=1 for the next cycle. rf_wena is 0 in cycles with no write issue.
- A granted read loads rf_raddr for the next cycle and tags the pending read with the client ID. rf_rdout is captured into that client's rdata, and its rvalid pulses.
- rf_raddr holds its last value when idle.

init_start:
- In IDLE, init_start has priority over requests: no grants that cycle, and the next state is INIT with cnt=0.
- init_start in INIT is ignored.

INIT:
- init_busy=1 and no grants.
- Each cycle loads rf_waddr=cnt, rf_wdin=INIT_VALUE, rf_wena=1 for the next cycle, then increments cnt.
- After cnt=DEPTH-1 the state returns to IDLE. cnt does not wrap into a second pass.
- Priority pointer is unchanged across INIT.

Other rules:
- Reset mid-INIT: sweep abandoned, next cycle IDLE with init_busy=0 and rf_wena=0. Entries already written stay written.
- Reset with a read in flight: the read is dropped and no rvalid is produced.

## Timing

- Request granted in cycle N → rf port driven in N+1.
- Write: committed at the edge ending N+1.
- Read: rf_raddr valid in N+1; x_rdata/x_rvalid valid in N+2 (rvalid high for exactly N+2).
- Back-to-back grants every cycle are supported (throughput 1 op/cycle).
- Read-after-write needs no bypass: a write granted in N and a read of the same address granted in N+1 returns the new data.
- Init sequence for init_start sampled in N:
  - init_busy is high N+1..N+DEPTH.
  - rf_wena is high N+2..N+DEPTH+1 with rf_waddr 0..DEPTH-1.
  - Grants are possible again from N+DEPTH+1.
- An op granted in N-1 still issues in N, unaffected by init_start.

## Test plan

- Reset, then A writes 0xDEADBEEF to addr 5 and later reads addr 5 → a_gnt in request cycle, rf_wena=1/rf_waddr=5 the next cycle, a_rvalid 2 cycles after the read grant with a_rdata=0xDEADBEEF, b_rvalid stays 0.
- A and B request reads continuously for 6 cycles → grants alternate A,B,A,B,A,B starting with A after reset. Each rvalid arrives exactly 2 cycles after its own grant, with no gaps in rf_raddr issue.
- A writes 0x1234 to addr 63 in cycle N, B reads addr 63 in N+1 → b_rdata=0x1234 at N+3.
- Fill addrs 0..63 with nonzero data, pulse init_start while both clients request:
  - init_busy high for 64 cycles and no grants during it.
  - rf_wena high 64 consecutive cycles with waddr 0..63.
  - After completion, reads of 0, 31 and 63 return 0x00000000.
  - The pointer is preserved: B is granted first if B held priority before init.
- Pulse init_start, assert rst at the 10th INIT cycle → next cycle init_busy=0 and rf_wena=0. Addresses 0..7 read back 0 and addresses ≥9 read back their old data. Address 8 is the write issued in the reset cycle; its result is implementation-specific and not checked.
- init_start asserted again while init_busy=1 → ignored, sweep ends on the original schedule.
